// File: rtl/if_queue_if.sv
// if_queue_if: push side (ifu) and pop side (IF/ID) bundle of the instruction fetch queue.
// Trap width comes from the TRAP_LEN macro (defaults to 3: misaligned, access fault, page fault).
`ifndef TRAP_LEN
`define TRAP_LEN 3
`endif
interface if_queue_if #(
    parameter int PTR_W = 2
);
    logic                 in_valid_i;
    logic [31:0]          in_pc_i;
    logic [31:0]          in_inst_i;
    logic [`TRAP_LEN-1:0] in_trap_i;
    logic                 in_pdt_taken_i;
    logic [31:0]          in_pdt_tag_i;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic [31:0]          out_pc_o;
    logic [31:0]          out_inst_o;
    logic [`TRAP_LEN-1:0] out_trap_o;
    logic                 out_pdt_taken_o;
    logic [31:0]          out_pdt_tag_o;
    logic                 out_ready_i;
    logic                 flush_i;
    logic [PTR_W:0]       count_o;

    modport slave (
        input  in_valid_i, in_pc_i, in_inst_i, in_trap_i, in_pdt_taken_i, in_pdt_tag_i,
        input  out_ready_i, flush_i,
        output in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_trap_o,
        output out_pdt_taken_o, out_pdt_tag_o, count_o
    );

    modport master (
        output in_valid_i, in_pc_i, in_inst_i, in_trap_i, in_pdt_taken_i, in_pdt_tag_i,
        output out_ready_i, flush_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_trap_o,
        input  out_pdt_taken_o, out_pdt_tag_o, count_o
    );
endinterface

// File: rtl/if_queue.sv
// if_queue: circular instruction fetch queue between ifu and IF/ID with flush and trap freeze.
// Optional IFQ_BYPASS_EN: an empty queue forwards the incoming fetch combinationally.
`ifndef TRAP_LEN
`define TRAP_LEN 3
`endif
module if_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       rst_n,
    if_queue_if.slave q
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [PTR_W:0]       wr_q, wr_d, rd_q, rd_d;
    logic                 hold_q, hold_d;
    logic [31:0]          pc_q    [DEPTH];
    logic [31:0]          inst_q  [DEPTH];
    logic [31:0]          tag_q   [DEPTH];
    logic [`TRAP_LEN-1:0] trap_q  [DEPTH];
    logic                 taken_q [DEPTH];
    logic [PTR_W-1:0]     wr_idx, rd_idx;
    logic                 empty, full, push, pop, byp, byp_take, wr_en, rd_en;

    assign wr_idx = wr_q[PTR_W-1:0];
    assign rd_idx = rd_q[PTR_W-1:0];
    assign empty  = wr_q == rd_q;
    assign full   = (wr_idx == rd_idx) && (wr_q[PTR_W] != rd_q[PTR_W]);

    // Depends only on state and flush, never on out_ready_i.
    assign q.in_ready_o = !full && !hold_q && !q.flush_i;

`ifdef IFQ_BYPASS_EN
    assign byp = empty && q.in_valid_i && q.in_ready_o;
`else
    assign byp = 1'b0;
`endif

    assign q.out_valid_o = (!empty || byp) && !q.flush_i;
    assign push          = q.in_valid_i && q.in_ready_o;
    assign pop           = q.out_valid_o && q.out_ready_i;
    // A bypassed fetch consumed in the same cycle never touches storage or pointers.
    assign byp_take      = byp && q.out_ready_i;
    assign wr_en         = push && !byp_take;
    assign rd_en         = pop && !byp_take;
    assign q.count_o     = wr_q - rd_q;

    // Head presentation: bypassed fetch, stored head, or a NOP bubble when nothing is valid.
    always_comb begin
        q.out_pc_o        = '0;
        q.out_inst_o      = NOP;
        q.out_trap_o      = '0;
        q.out_pdt_taken_o = 1'b0;
        q.out_pdt_tag_o   = '0;
        if (q.out_valid_o) begin
            q.out_pc_o        = byp ? q.in_pc_i        : pc_q[rd_idx];
            q.out_inst_o      = byp ? q.in_inst_i      : inst_q[rd_idx];
            q.out_trap_o      = byp ? q.in_trap_i      : trap_q[rd_idx];
            q.out_pdt_taken_o = byp ? q.in_pdt_taken_i : taken_q[rd_idx];
            q.out_pdt_tag_o   = byp ? q.in_pdt_tag_i   : tag_q[rd_idx];
        end
    end

    // Pointer and trap-hold next state; flush wipes everything and wins over push/pop.
    always_comb begin
        wr_d   = wr_q + {{PTR_W{1'b0}}, wr_en};
        rd_d   = rd_q + {{PTR_W{1'b0}}, rd_en};
        hold_d = hold_q || (push && |q.in_trap_i);
        if (q.flush_i) begin
            wr_d   = '0;
            rd_d   = '0;
            hold_d = 1'b0;
        end
    end

    // Control state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            hold_q <= hold_d;
        end
    end

    // Entry storage, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_q[wr_idx]    <= q.in_pc_i;
            inst_q[wr_idx]  <= q.in_inst_i;
            trap_q[wr_idx]  <= q.in_trap_i;
            taken_q[wr_idx] <= q.in_pdt_taken_i;
            tag_q[wr_idx]   <= q.in_pdt_tag_i;
        end
    end
endmodule

// File: tb/tb_if_queue.sv
// tb_if_queue: randomized + directed bench for if_queue with a queue-based reference model and scoreboard.
`ifndef TRAP_LEN
`define TRAP_LEN 3
`endif
module tb_if_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int TL = `TRAP_LEN;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   inst;
        logic [TL-1:0] trap;
        logic          tk;
        logic [31:0]   tag;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    ent_t sb[$];
    bit hold_m = 0;
    bit popped = 0;
    bit byp_used = 0;

    if_queue_if #(.PTR_W(PTR_W)) b ();
    if_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .q(b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: plain FIFO of accepted fetches, updated at each edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_m = 0;
        end else begin
            if (b.flush_i) begin
                sb.delete();
                hold_m = 0;
            end else if (b.in_valid_i && !hold_m && (sb.size() + int'(popped)) < DEPTH) begin
                if (b.in_trap_i != '0) hold_m = 1;
                if (!byp_used)
                    sb.push_back('{b.in_pc_i, b.in_inst_i, b.in_trap_i, b.in_pdt_taken_i, b.in_pdt_tag_i});
            end
        end
        popped = 0;
        byp_used = 0;
    end

    // Monitor: checks status outputs and head contents mid-cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        int n;
        bit byp;
        ent_t e;
        n = sb.size();
        byp = 0;
        if (rst_n) begin
`ifdef IFQ_BYPASS_EN
            byp = (n == 0) && b.in_valid_i && !hold_m && !b.flush_i;
`endif
            chk("in_ready", 64'(b.in_ready_o), 64'(!b.flush_i && n < DEPTH && !hold_m));
            chk("count", 64'(b.count_o), 64'(n));
            chk("out_valid", 64'(b.out_valid_o), 64'(!b.flush_i && (n > 0 || byp)));
            if (!b.flush_i && n > 0) e = sb[0];
            else if (!b.flush_i && byp) e = '{b.in_pc_i, b.in_inst_i, b.in_trap_i, b.in_pdt_taken_i, b.in_pdt_tag_i};
            else e = '{32'h0, NOP, '0, 1'b0, 32'h0};
            chk("out_pc", 64'(b.out_pc_o), 64'(e.pc));
            chk("out_inst", 64'(b.out_inst_o), 64'(e.inst));
            chk("out_trap", 64'(b.out_trap_o), 64'(e.trap));
            chk("out_taken", 64'(b.out_pdt_taken_o), 64'(e.tk));
            chk("out_tag", 64'(b.out_pdt_tag_o), 64'(e.tag));
            if (b.out_valid_o && b.out_ready_i && !b.flush_i) begin
                if (n > 0) begin
                    void'(sb.pop_front());
                    popped = 1;
                end else if (byp) byp_used = 1;
            end
        end
    end

    task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl, input logic [TL-1:0] tr);
        b.in_valid_i = v;
        b.in_pc_i = pc;
        b.in_inst_i = $urandom;
        b.in_trap_i = tr;
        b.in_pdt_taken_i = 1'($urandom);
        b.in_pdt_tag_i = $urandom;
        b.out_ready_i = rdy;
        b.flush_i = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(b.out_valid_o), 64'(0));
        chk("rst_out_inst", 64'(b.out_inst_o), 64'(NOP));
        chk("rst_count", 64'(b.count_o), 64'(0));
        sb.delete();
        hold_m = 0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        b.in_valid_i = 0; b.in_pc_i = 0; b.in_inst_i = 0; b.in_trap_i = '0;
        b.in_pdt_taken_i = 0; b.in_pdt_tag_i = 0; b.out_ready_i = 0; b.flush_i = 0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 0, '0);
        // Fill without drain, one refused extra push, then drain in order.
        for (int i = 0; i < 4; i++) step(1, 32'h8000_0000 + 32'(4 * i), 0, 0, '0);
        step(1, 32'h8000_0010, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, '0);
        // Steady push/pop at occupancy 2 across pointer wrap.
        step(1, 32'h8000_0100, 0, 0, '0);
        step(1, 32'h8000_0104, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(1, 32'h8000_0108 + 32'(4 * i), 1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
        // Flush while holding 3 entries with a push offered.
        for (int i = 0; i < 3; i++) step(1, 32'h8000_0200 + 32'(4 * i), 0, 0, '0);
        step(1, 32'h8000_020C, 1, 1, '0);
        step(0, 0, 1, 0, '0);
        // Trapping fetch freezes intake until flush, trap entry still drains.
        step(1, 32'h8000_0010, 0, 0, TL'(4));
        for (int i = 0; i < 3; i++) step(1, 32'h8000_0014 + 32'(4 * i), 0, 0, '0);
        for (int i = 0; i < 3; i++) step(1, 32'h8000_0020 + 32'(4 * i), 1, 0, '0);
        step(1, 32'h8000_0030, 1, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 32'h8000_0040 + 32'(4 * i), 1, 0, '0);
        // Asynchronous reset pulse mid-stream.
        step(1, 32'h8000_0050, 0, 0, '0);
        step(1, 32'h8000_0054, 0, 0, '0);
        reset_pulse();
        step(0, 0, 0, 0, '0);
        // Empty queue, fetch offered and consumed at once (bypass case when enabled).
        step(1, 32'h8000_0020, 1, 0, '0);
        step(0, 0, 1, 0, '0);
        // Randomized traffic.
        pc = 32'h8000_1000;
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) != 0, pc, ($urandom % 3) != 0, ($urandom % 20) == 0,
                 (($urandom % 16) == 0) ? TL'(1 << ($urandom % TL)) : '0);
            pc += 4;
        end
        step(0, 0, 1, 0, '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
